// File: rtl/keycode_motion_pkg.sv
// rtl/keycode_motion_pkg.sv - shared types and constants for the keycode motion block
// Purpose : motion state enum, HID keycodes for W/A/S/D, coordinate width.
// Ports   : none (package).
package keycode_motion_pkg;

   localparam int COORD_W = 10;

   typedef enum logic [2:0] {
      STOP  = 3'd0,
      UP    = 3'd1,
      DOWN  = 3'd2,
      LEFT  = 3'd3,
      RIGHT = 3'd4
   } motion_e;

   localparam logic [7:0] KC_W = 8'h1A;
   localparam logic [7:0] KC_A = 8'h04;
   localparam logic [7:0] KC_S = 8'h16;
   localparam logic [7:0] KC_D = 8'h07;

endpackage

// File: rtl/vsync_edge_detect.sv
// rtl/vsync_edge_detect.sv - vsync synchroniser with one-cycle falling-edge strobe
// Purpose : brings the asynchronous active-low vsync into the clock domain and
//           emits a registered one-cycle pulse three clocks after it falls.
// Ports   : i_clk       - system clock
//           i_rst_n     - async active-low reset
//           i_vs_n      - raw active-low vertical sync
//           o_fall_tick - one-cycle pulse per synchronised falling edge
module vsync_edge_detect (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_vs_n,
   output logic o_fall_tick
);

   logic r_sync1;
   logic r_sync2;
   logic r_vs_prev;
   logic r_tick;

   // All stages reset to the idle-high level so releasing reset while vsync
   // is high never looks like an edge; a pending pulse is discarded.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_vs_prev <= 1'b1;
         r_tick    <= 1'b0;
      end else begin
         r_sync1   <= i_vs_n;
         r_sync2   <= r_sync1;
         r_vs_prev <= r_sync2;
         r_tick    <= r_vs_prev & ~r_sync2;
      end
   end

   assign o_fall_tick = r_tick;

endmodule

// File: rtl/keycode_motion_ctrl.sv
// rtl/keycode_motion_ctrl.sv - per-frame keycode driven sprite motion with edge bounce
// Purpose : once per VGA frame decodes W/A/S/D into a direction, bounces off the
//           screen edges and steps a square sprite; exposes centre, size, state
//           and a debug word for the hex display.
// Option  : KEYCODE_MOTION_HOLD_EN - keycode 0 on a tick forces STOP (move only
//           while a key is held). Undefined: last direction persists.
// Ports   : clk_clk       - system clock
//           reset_reset_n - async active-low reset
//           keycode       - HID keycode, 0 = no key
//           vga_vs        - active-low vertical sync
//           ball_x/ball_y - sprite centre
//           ball_size     - sprite half-width
//           motion        - current motion state
//           frame_tick    - one-cycle frame update strobe
//           hex_dbg       - {ball_x[7:0], ball_y[7:0]}
module keycode_motion_ctrl
   import keycode_motion_pkg::*;
#(
   parameter int X_MIN    = 0,
   parameter int X_MAX    = 639,
   parameter int Y_MIN    = 0,
   parameter int Y_MAX    = 479,
   parameter int X_CENTER = 320,
   parameter int Y_CENTER = 240,
   parameter int STEP     = 1,
   parameter int SIZE     = 4
) (
   input  logic               clk_clk,
   input  logic               reset_reset_n,
   input  logic [7:0]         keycode,
   input  logic               vga_vs,
   output logic [COORD_W-1:0] ball_x,
   output logic [COORD_W-1:0] ball_y,
   output logic [COORD_W-1:0] ball_size,
   output motion_e            motion,
   output logic               frame_tick,
   output logic [15:0]        hex_dbg
);

   // One extra bit so that position minus step/size cannot wrap below zero.
   localparam int SW = COORD_W + 1;

   localparam logic signed [SW-1:0] L_STEP  = SW'(STEP);
   localparam logic signed [SW-1:0] L_SIZE  = SW'(SIZE);
   localparam logic signed [SW-1:0] L_X_MIN = SW'(X_MIN);
   localparam logic signed [SW-1:0] L_X_MAX = SW'(X_MAX);
   localparam logic signed [SW-1:0] L_Y_MIN = SW'(Y_MIN);
   localparam logic signed [SW-1:0] L_Y_MAX = SW'(Y_MAX);
   localparam logic signed [SW-1:0] L_X_LO  = SW'(X_MIN + SIZE);
   localparam logic signed [SW-1:0] L_X_HI  = SW'(X_MAX - SIZE);
   localparam logic signed [SW-1:0] L_Y_LO  = SW'(Y_MIN + SIZE);
   localparam logic signed [SW-1:0] L_Y_HI  = SW'(Y_MAX - SIZE);

   logic                      w_tick;
   motion_e                   r_state;
   motion_e                   w_key_state;
   motion_e                   w_next_state;
   logic [COORD_W-1:0]        r_x;
   logic [COORD_W-1:0]        r_y;
   logic signed [SW-1:0]      w_x_s;
   logic signed [SW-1:0]      w_y_s;
   logic signed [SW-1:0]      w_x_new;
   logic signed [SW-1:0]      w_y_new;

   vsync_edge_detect u_vsync_edge_detect (
      .i_clk       (clk_clk),
      .i_rst_n     (reset_reset_n),
      .i_vs_n      (vga_vs),
      .o_fall_tick (w_tick)
   );

   assign w_x_s = signed'({1'b0, r_x});
   assign w_y_s = signed'({1'b0, r_y});

   // State register
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state <= STOP;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state: key decode first, then the wall check on the decoded direction
   // so that a wall always wins over the key pressed in the same frame.
   always_comb begin
      w_key_state = r_state;
      case (keycode)
         KC_W:    w_key_state = UP;
         KC_S:    w_key_state = DOWN;
         KC_A:    w_key_state = LEFT;
         KC_D:    w_key_state = RIGHT;
         default: begin
`ifdef KEYCODE_MOTION_HOLD_EN
            if (keycode == 8'h00) begin
               w_key_state = STOP;
            end
`else
            w_key_state = r_state;
`endif
         end
      endcase

      w_next_state = w_key_state;
      case (w_key_state)
         UP:      if (w_y_s - L_SIZE <= L_Y_MIN + L_STEP) w_next_state = DOWN;
         DOWN:    if (w_y_s + L_SIZE >= L_Y_MAX - L_STEP) w_next_state = UP;
         LEFT:    if (w_x_s - L_SIZE <= L_X_MIN + L_STEP) w_next_state = RIGHT;
         RIGHT:   if (w_x_s + L_SIZE >= L_X_MAX - L_STEP) w_next_state = LEFT;
         default: w_next_state = w_key_state;
      endcase

      if (!w_tick) begin
         w_next_state = r_state;
      end
   end

   // Candidate position from the new state, clamped so it can never leave the screen.
   always_comb begin
      w_x_new = w_x_s;
      w_y_new = w_y_s;
      case (w_next_state)
         UP:      w_y_new = w_y_s - L_STEP;
         DOWN:    w_y_new = w_y_s + L_STEP;
         LEFT:    w_x_new = w_x_s - L_STEP;
         RIGHT:   w_x_new = w_x_s + L_STEP;
         default: ;
      endcase
      if (w_x_new < L_X_LO) w_x_new = L_X_LO;
      if (w_x_new > L_X_HI) w_x_new = L_X_HI;
      if (w_y_new < L_Y_LO) w_y_new = L_Y_LO;
      if (w_y_new > L_Y_HI) w_y_new = L_Y_HI;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_x <= COORD_W'(X_CENTER);
         r_y <= COORD_W'(Y_CENTER);
      end else if (w_tick) begin
         r_x <= COORD_W'(w_x_new);
         r_y <= COORD_W'(w_y_new);
      end
   end

   // Outputs
   always_comb begin
      motion     = r_state;
      frame_tick = w_tick;
      ball_x     = r_x;
      ball_y     = r_y;
      ball_size  = COORD_W'(SIZE);
      hex_dbg    = {r_x[7:0], r_y[7:0]};
   end

endmodule

// File: tb/tb_keycode_motion_ctrl.sv
// tb/tb_keycode_motion_ctrl.sv - directed self-checking bench for keycode_motion_ctrl
module tb_keycode_motion_ctrl;
   import keycode_motion_pkg::*;

   logic        clk_clk = 1'b0;
   logic        reset_reset_n = 1'b0;
   logic [7:0]  keycode = 8'h00;
   logic        vga_vs = 1'b1;
   logic [9:0]  ball_x;
   logic [9:0]  ball_y;
   logic [9:0]  ball_size;
   motion_e     motion;
   logic        frame_tick;
   logic [15:0] hex_dbg;

   int total = 0;
   int bad = 0;
   int tick_cnt = 0;
   int max_x = 0;
   int saved_ticks;
   int y_exp;

   always #5 clk_clk = ~clk_clk;

   keycode_motion_ctrl dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .keycode       (keycode),
      .vga_vs        (vga_vs),
      .ball_x        (ball_x),
      .ball_y        (ball_y),
      .ball_size     (ball_size),
      .motion        (motion),
      .frame_tick    (frame_tick),
      .hex_dbg       (hex_dbg)
   );

   always @(negedge clk_clk) begin
      if (frame_tick) tick_cnt++;
      if (int'(ball_x) > max_x) max_x = int'(ball_x);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic frame_plain();
      vga_vs = 1'b0;
      repeat (4) @(negedge clk_clk);
      vga_vs = 1'b1;
      repeat (4) @(negedge clk_clk);
   endtask

   task automatic frame_detail(input string tag, input int x0, input int y0,
                               input int x1, input int y1);
      vga_vs = 1'b0;
      @(negedge clk_clk);
      check({tag, "_tick_c1"}, 32'(frame_tick), 32'd0);
      @(negedge clk_clk);
      check({tag, "_tick_c2"}, 32'(frame_tick), 32'd0);
      @(negedge clk_clk);
      check({tag, "_tick_c3"}, 32'(frame_tick), 32'd1);
      check({tag, "_x_at_tick"}, 32'(ball_x), 32'(x0));
      check({tag, "_y_at_tick"}, 32'(ball_y), 32'(y0));
      @(negedge clk_clk);
      check({tag, "_tick_c4"}, 32'(frame_tick), 32'd0);
      check({tag, "_x_after"}, 32'(ball_x), 32'(x1));
      check({tag, "_y_after"}, 32'(ball_y), 32'(y1));
      vga_vs = 1'b1;
      repeat (4) @(negedge clk_clk);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk_clk);
      check("rst_x", 32'(ball_x), 32'd320);
      check("rst_y", 32'(ball_y), 32'd240);
      check("rst_motion", 32'(motion), 32'(STOP));
      check("rst_tick", 32'(frame_tick), 32'd0);
      check("rst_size", 32'(ball_size), 32'd4);
      check("rst_hex", 32'(hex_dbg), 32'h40F0);
      reset_reset_n = 1'b1;
      repeat (2) @(negedge clk_clk);

      // 1: three frames, no key
      frame_detail("t1_f1", 320, 240, 320, 240);
      frame_detail("t1_f2", 320, 240, 320, 240);
      frame_detail("t1_f3", 320, 240, 320, 240);
      check("t1_tick_cnt", 32'(tick_cnt), 32'd3);
      check("t1_motion", 32'(motion), 32'(STOP));
      check("t1_hex", 32'(hex_dbg), 32'h40F0);

      // 2: D held for five frames
      keycode = 8'h07;
      frame_detail("t2_f1", 320, 240, 321, 240);
      frame_detail("t2_f2", 321, 240, 322, 240);
      frame_detail("t2_f3", 322, 240, 323, 240);
      frame_detail("t2_f4", 323, 240, 324, 240);
      frame_detail("t2_f5", 324, 240, 325, 240);
      check("t2_motion", 32'(motion), 32'(RIGHT));
      check("t2_hex", 32'(hex_dbg), 32'h45F0);

      // 3: run to the right wall and bounce
      repeat (308) frame_plain();
      check("t3_x_633", 32'(ball_x), 32'd633);
      check("t3_motion_pre", 32'(motion), 32'(RIGHT));
      frame_detail("t3_to634", 633, 240, 634, 240);
      check("t3_motion_634", 32'(motion), 32'(RIGHT));
      frame_detail("t3_bounce", 634, 240, 633, 240);
      check("t3_motion_bounce", 32'(motion), 32'(LEFT));
      check("t3_max_x", 32'(max_x), 32'd634);

      // 4: W held up to the top wall; bounce beats the key
      keycode = 8'h1A;
      repeat (235) frame_plain();
      check("t4_y_5", 32'(ball_y), 32'd5);
      check("t4_x_hold", 32'(ball_x), 32'd633);
      check("t4_motion_up", 32'(motion), 32'(UP));
      frame_detail("t4_bounce", 633, 5, 633, 6);
      check("t4_motion_down", 32'(motion), 32'(DOWN));

      // 5: unmapped key keeps direction; key release per build option
      keycode = 8'h16;
      repeat (10) frame_plain();
      check("t5_y_16", 32'(ball_y), 32'd16);
      keycode = 8'h1A;
      frame_plain();
      check("t5_y_15", 32'(ball_y), 32'd15);
      keycode = 8'h2C;
      repeat (3) frame_plain();
      check("t5_unmapped_motion", 32'(motion), 32'(UP));
      check("t5_unmapped_y", 32'(ball_y), 32'd12);
      keycode = 8'h00;
      repeat (2) frame_plain();
`ifdef KEYCODE_MOTION_HOLD_EN
      check("t5_release_motion", 32'(motion), 32'(STOP));
      check("t5_release_y", 32'(ball_y), 32'd12);
      check("t5_release_hex", 32'(hex_dbg), 32'h790C);
      y_exp = 11;
`else
      check("t5_release_motion", 32'(motion), 32'(UP));
      check("t5_release_y", 32'(ball_y), 32'd10);
      check("t5_release_hex", 32'(hex_dbg), 32'h790A);
      y_exp = 9;
`endif

      // 6: reset mid-frame while moving, tick pending
      keycode = 8'h1A;
      frame_plain();
      check("t6_moving_y", 32'(ball_y), 32'(y_exp));
      check("t6_moving_motion", 32'(motion), 32'(UP));
      vga_vs = 1'b0;
      @(negedge clk_clk);
      @(negedge clk_clk);
      check("t6_pre_tick", 32'(frame_tick), 32'd0);
      saved_ticks = tick_cnt;
      reset_reset_n = 1'b0;
      vga_vs = 1'b1;
      #1;
      check("t6_async_x", 32'(ball_x), 32'd320);
      check("t6_async_y", 32'(ball_y), 32'd240);
      check("t6_async_motion", 32'(motion), 32'(STOP));
      check("t6_async_tick", 32'(frame_tick), 32'd0);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      repeat (8) @(negedge clk_clk);
      check("t6_no_spurious", 32'(tick_cnt), 32'(saved_ticks));
      check("t6_post_x", 32'(ball_x), 32'd320);
      check("t6_post_y", 32'(ball_y), 32'd240);
      check("t6_post_motion", 32'(motion), 32'(STOP));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
